// File: rtl/tx_step_gen_pkg.sv
// Shared time format, history defaults and step-entry type for the TX step generator.
// Also holds the wrap-safe age/expiry helper used on every history entry.
package tx_step_gen_pkg;

    localparam int unsigned TIME_WIDTH = 16;

    typedef logic [TIME_WIDTH-1:0] time_format_t;

    localparam int unsigned  TX_STEP_DEPTH    = 8;
    localparam time_format_t TX_PULSE_AGE_VAL = 16'd50;

    typedef struct packed {
        time_format_t t;
        logic         pol;
        logic         valid;
    } tx_step_t;

    // Modular subtraction keeps the age correct across a wrap of the time counter.
    function automatic logic is_expired(input time_format_t now, input time_format_t t,
                                        input time_format_t max_age);
        time_format_t age;
        age = now - t;
        return (age >= max_age);
    endfunction

endpackage

// File: rtl/tx_step_gen_if.sv
// TX step generator bus: TX clock stage inputs and step-history outputs.
// Optional tx_data_in exists only when TX_EXT_DATA_EN is defined.
interface tx_step_gen_if
    import tx_step_gen_pkg::*;
#(
    parameter int unsigned DEPTH = TX_STEP_DEPTH
) ();

    time_format_t                    time_now;
    time_format_t                    time_clock;
    logic                            cke_in;
    logic                            time_eq;
`ifdef TX_EXT_DATA_EN
    logic                            tx_data_in;
`endif
    logic                            tx_bit;
    logic [DEPTH*TIME_WIDTH-1:0]     step_time;
    logic [DEPTH-1:0]                step_pol;
    logic [DEPTH-1:0]                step_valid;
    logic                            overflow;

    modport master (
`ifdef TX_EXT_DATA_EN
        output tx_data_in,
`endif
        output time_now,
        output time_clock,
        output cke_in,
        output time_eq,
        input  tx_bit,
        input  step_time,
        input  step_pol,
        input  step_valid,
        input  overflow
    );

    modport slave (
`ifdef TX_EXT_DATA_EN
        input  tx_data_in,
`endif
        input  time_now,
        input  time_clock,
        input  cke_in,
        input  time_eq,
        output tx_bit,
        output step_time,
        output step_pol,
        output step_valid,
        output overflow
    );

endinterface

// File: rtl/prbs7_gen.sv
// PRBS7 source, x^7+x^6+1 Fibonacci form shifting left; advances only on adv.
// bit_out is the bit the next advance will shift in.
module prbs7_gen #(
    parameter logic [6:0] lfsr_init = 7'd2
) (
    input  logic clk,
    input  logic rst,
    input  logic adv,
    output logic bit_out
);

    logic [6:0] r_lfsr;

    assign bit_out = r_lfsr[6] ^ r_lfsr[5];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= lfsr_init;
        end else if (adv) begin
            r_lfsr <= {r_lfsr[5:0], bit_out};
        end
    end

endmodule

// File: rtl/tx_step_gen.sv
// TX bit source plus timestamped step-event history with age-based retirement.
// Define TX_EXT_DATA_EN to take bits from tx_data_in instead of the internal PRBS7.
module tx_step_gen
    import tx_step_gen_pkg::*;
#(
    parameter int unsigned  DEPTH     = TX_STEP_DEPTH,
    parameter time_format_t MAX_AGE   = TX_PULSE_AGE_VAL,
    parameter logic [6:0]   lfsr_init = 7'd2
) (
    input logic          clk,
    input logic          rst,
    tx_step_gen_if.slave bus
);

    logic     w_event;
    logic     w_new_bit;
    logic     w_push;
    logic     w_overflow_d;
    logic     r_tx_bit;
    logic     r_overflow;
    tx_step_t r_hist   [DEPTH];
    tx_step_t w_aged   [DEPTH];
    tx_step_t w_hist_d [DEPTH];

    assign w_event = bus.cke_in & bus.time_eq;
    assign w_push  = w_event & (w_new_bit != r_tx_bit);

`ifdef TX_EXT_DATA_EN
    assign w_new_bit = bus.tx_data_in;
`else
    prbs7_gen #(
        .lfsr_init (lfsr_init)
    ) u_prbs7_gen (
        .clk     (clk),
        .rst     (rst),
        .adv     (w_event),
        .bit_out (w_new_bit)
    );
`endif

    // Expiry is judged on the pre-shift slot, then carried along with the shift.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_aged[i]       = r_hist[i];
            w_aged[i].valid = r_hist[i].valid & ~is_expired(bus.time_now, r_hist[i].t, MAX_AGE);
        end
        w_hist_d     = w_aged;
        w_overflow_d = r_overflow;
        if (w_push) begin
            w_hist_d[0] = '{t: bus.time_clock, pol: w_new_bit, valid: 1'b1};
            for (int i = 1; i < int'(DEPTH); i++) begin
                w_hist_d[i] = w_aged[i-1];
            end
            w_overflow_d = r_overflow | w_aged[DEPTH-1].valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_bit   <= 1'b0;
            r_overflow <= 1'b0;
            r_hist     <= '{default: '0};
        end else begin
            if (w_event) begin
                r_tx_bit <= w_new_bit;
            end
            r_overflow <= w_overflow_d;
            r_hist     <= w_hist_d;
        end
    end

    always_comb begin
        bus.tx_bit     = r_tx_bit;
        bus.overflow   = r_overflow;
        bus.step_time  = '0;
        bus.step_pol   = '0;
        bus.step_valid = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            bus.step_time[i*TIME_WIDTH +: TIME_WIDTH] = r_hist[i].t;
            bus.step_pol[i]                           = r_hist[i].pol;
            bus.step_valid[i]                         = r_hist[i].valid;
        end
    end

endmodule
